// File: rtl/scroll_pkg.sv
// Shared types and constants for the scrolling hex display controller.
package scroll_pkg;

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;

  localparam logic [3:0] AN_IDLE   = 4'b1111;

endpackage

// File: rtl/hex7seg.sv
// Combinational hex digit to active-low seven-segment decoder.
module hex7seg
  import scroll_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_digit)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      4'hF: o_seg = SEG_F;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/scroll_ctrl.sv
// Run/stop scroll sequencer with load path and 4-digit multiplexed hex display.
// Optional macro SCROLL_DP_EN adds an active-low decimal-point output (dp).
module scroll_ctrl
  import scroll_pkg::*;
#(
  parameter int STEP_DIV = 25_000_000,
  parameter int SCAN_DIV = 50_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       dir,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] base,
  output logic       step_tick,
  output logic [3:0] an,
  output logic [6:0] seg
`ifdef SCROLL_DP_EN
  ,
  output logic       dp
`endif
);

  localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  state_t            r_state;
  logic [STEP_W-1:0] r_step_cnt;
  logic [3:0]        r_base;
  logic              r_tick;
  logic [SCAN_W-1:0] r_scan_cnt;
  logic [1:0]        r_scan_idx;
  logic [3:0]        r_an;
  logic [6:0]        r_seg;
  logic [3:0]        w_digit;
  logic [6:0]        w_seg;

  // Load wins over a due step; leaving RUN drops the partial count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= STOP;
      r_step_cnt <= '0;
      r_base     <= 4'h0;
      r_tick     <= 1'b0;
    end else begin
      r_state <= run ? RUN : STOP;
      r_tick  <= 1'b0;
      if (load) begin
        r_base     <= load_val;
        r_step_cnt <= '0;
      end else begin
        case (r_state)
          RUN: begin
            if (!run) begin
              r_step_cnt <= '0;
            end else if (r_step_cnt == STEP_LAST) begin
              r_step_cnt <= '0;
              r_base     <= dir ? r_base - 4'h1 : r_base + 4'h1;
              r_tick     <= 1'b1;
            end else begin
              r_step_cnt <= r_step_cnt + 1'b1;
            end
          end
          default: r_step_cnt <= '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scan_cnt <= '0;
      r_scan_idx <= 2'd0;
    end else if (r_scan_cnt == SCAN_LAST) begin
      r_scan_cnt <= '0;
      r_scan_idx <= r_scan_idx + 2'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  assign w_digit = r_base + {2'b00, r_scan_idx};

  hex7seg u_dec (
    .i_digit (w_digit),
    .o_seg   (w_seg)
  );

  // Scan index 0 is the leftmost digit, driven on an[3].
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_an  <= AN_IDLE;
      r_seg <= SEG_BLANK;
    end else begin
      r_an  <= ~(4'b1000 >> r_scan_idx);
      r_seg <= w_seg;
    end
  end

`ifdef SCROLL_DP_EN
  logic r_dp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dp <= 1'b1;
    end else begin
      r_dp <= !((r_scan_idx == 2'd3) && (r_state == RUN));
    end
  end

  assign dp = r_dp;
`endif

  assign base      = r_base;
  assign step_tick = r_tick;
  assign an        = r_an;
  assign seg       = r_seg;

endmodule

// File: tb/tb_scroll_ctrl.sv
// Directed bench for scroll_ctrl with STEP_DIV=4, SCAN_DIV=2.
module tb_scroll_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       dir = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'h0;
  logic [3:0] base;
  logic       step_tick;
  logic [3:0] an;
  logic [6:0] seg;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [3:0] an_tab  [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
  logic [6:0] seg_tab [4] = '{7'b0000110, 7'b0001110, 7'b1000000, 7'b1111001};

  always #5 clk = ~clk;

  scroll_ctrl #(
    .STEP_DIV (4),
    .SCAN_DIV (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .dir       (dir),
    .load      (load),
    .load_val  (load_val),
    .base      (base),
    .step_tick (step_tick),
    .an        (an),
    .seg       (seg)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] e_base, input logic e_tick);
    n_cmp++;
    assert (base === e_base) else begin
      n_fail++;
      $error("FAIL %s base: got %h expected %h", tag, base, e_base);
    end
    n_cmp++;
    assert (step_tick === e_tick) else begin
      n_fail++;
      $error("FAIL %s step_tick: got %b expected %b", tag, step_tick, e_tick);
    end
  endtask

  task automatic chk_disp(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg);
    n_cmp++;
    assert (an === e_an) else begin
      n_fail++;
      $error("FAIL %s an: got %b expected %b", tag, an, e_an);
    end
    n_cmp++;
    assert (seg === e_seg) else begin
      n_fail++;
      $error("FAIL %s seg: got %b expected %b", tag, seg, e_seg);
    end
  endtask

  // Asserted mid-cycle; outputs must clear before any clock edge.
  task automatic rst_pulse();
    rst = 1'b0;
    #3;
    chk_out("reset", 4'h0, 1'b0);
    chk_disp("reset", 4'b1111, 7'b1111111);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    rst_pulse();

    // Hold, load E, and watch the scan walk the four digits.
    load     = 1'b1;
    load_val = 4'hE;
    step(1);
    chk_out("scan_load", 4'hE, 1'b0);
    chk_disp("scan_first", 4'b0111, 7'b1000000);
    load = 1'b0;
    for (int j = 2; j <= 9; j++) begin
      step(1);
      chk_disp("scan", an_tab[((j - 1) / 2) % 4], seg_tab[((j - 1) / 2) % 4]);
      chk_out("scan_hold", 4'hE, 1'b0);
    end

    // Up-scroll through a full wrap.
    rst_pulse();
    run = 1'b1;
    dir = 1'b0;
    step(1);
    for (int i = 1; i <= 16; i++) begin
      for (int k = 1; k <= 4; k++) begin
        step(1);
        if (k < 4) chk_out("up_wait", 4'(i - 1), 1'b0);
        else       chk_out("up_step", 4'(i), 1'b1);
      end
    end

    // Down-scroll from 0 wraps to F; then the scan shows F,0,1,2.
    rst_pulse();
    run = 1'b1;
    dir = 1'b1;
    step(1);
    step(3);
    chk_out("dn_pre", 4'h0, 1'b0);
    step(1);
    chk_out("dn_first", 4'hF, 1'b1);
    run = 1'b0;
    step(1);
    chk_disp("dn_idx2", 4'b1101, 7'b1111001);
    chk_out("dn_hold", 4'hF, 1'b0);
    step(1);
    chk_disp("dn_idx3", 4'b1110, 7'b0100100);
    step(2);
    chk_disp("dn_idx0", 4'b0111, 7'b0001110);
    step(2);
    chk_disp("dn_idx1", 4'b1011, 7'b1000000);
    chk_out("dn_hold2", 4'hF, 1'b0);

    // Load coincident with a due step.
    rst_pulse();
    run = 1'b1;
    dir = 1'b0;
    step(1);
    step(3);
    chk_out("ld_pre", 4'h0, 1'b0);
    load     = 1'b1;
    load_val = 4'hA;
    step(1);
    chk_out("ld_win", 4'hA, 1'b0);
    load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk_out("ld_wait", 4'hA, 1'b0);
    end
    step(1);
    chk_out("ld_next", 4'hB, 1'b1);

    // Stop after two counted cycles; restart must count a full period.
    step(2);
    chk_out("stop_pre", 4'hB, 1'b0);
    run = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(1);
      chk_out("stop_hold", 4'hB, 1'b0);
    end
    run = 1'b1;
    step(1);
    chk_out("restart", 4'hB, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk_out("restart_wait", 4'hB, 1'b0);
    end
    step(1);
    chk_out("restart_step", 4'hC, 1'b1);

    // Direction flip mid-period applies to the next step without clearing the count.
    step(2);
    dir = 1'b1;
    step(1);
    chk_out("dir_wait", 4'hC, 1'b0);
    step(1);
    chk_out("dir_step", 4'hB, 1'b1);

    // Reset while running; FSM restarts from STOP, run held high.
    step(1);
    rst_pulse();
    dir = 1'b0;
    step(1);
    chk_out("rerun_start", 4'h0, 1'b0);
    step(3);
    chk_out("rerun_wait", 4'h0, 1'b0);
    step(1);
    chk_out("rerun_step", 4'h1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
